// File: rtl/order_entry_tx_pkg.sv
// rtl/order_entry_tx_pkg.sv - order message constants and TX state encoding
package order_entry_tx_pkg;

    localparam logic [7:0] ORD_MSG_TYPE  = 8'h4F;
    localparam logic [7:0] ORD_SIDE_BUY  = 8'h42;
    localparam logic [7:0] ORD_SIDE_SELL = 8'h53;
    localparam int         ORD_MSG_LEN   = 19;
    localparam logic [4:0] ORD_LAST_IDX  = 5'(ORD_MSG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } ord_state_t;

endpackage

// File: rtl/order_entry_tx.sv
// rtl/order_entry_tx.sv - serializes one order request into a 19-byte big-endian message
module order_entry_tx
    import order_entry_tx_pkg::*;
#(
    parameter logic [31:0] SEQ_INIT   = 32'd1,
    parameter int          IFG_CYCLES = 4
) (
    input  logic        clk_sys,
    input  logic        rstn,
    input  logic        ord_valid,
    output logic        ord_ready,
    input  logic [31:0] ord_id,
    input  logic        ord_side,
    input  logic [31:0] ord_price,
    input  logic [31:0] ord_qty,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic [31:0] msg_count,
    output logic [31:0] reject_count
);

    localparam logic [15:0] GAP_LOAD = 16'(IFG_CYCLES);

    ord_state_t   state, state_next;
    logic [143:0] frame;
    logic [4:0]   idx;
    logic [7:0]   acc;
    logic [7:0]   cur_byte;
    logic [31:0]  seq;
    logic [15:0]  gap_cnt;
    logic         accept;
    logic         tx_fire;

    assign accept  = ord_valid & ord_ready;
    assign tx_fire = tx_valid & tx_ready;

    // Bytes 0..17 come from the latched frame; index 18 is the running checksum.
    always_comb begin
        cur_byte = acc;
        case (idx)
            5'd0:    cur_byte = frame[143:136];
            5'd1:    cur_byte = frame[135:128];
            5'd2:    cur_byte = frame[127:120];
            5'd3:    cur_byte = frame[119:112];
            5'd4:    cur_byte = frame[111:104];
            5'd5:    cur_byte = frame[103:96];
            5'd6:    cur_byte = frame[95:88];
            5'd7:    cur_byte = frame[87:80];
            5'd8:    cur_byte = frame[79:72];
            5'd9:    cur_byte = frame[71:64];
            5'd10:   cur_byte = frame[63:56];
            5'd11:   cur_byte = frame[55:48];
            5'd12:   cur_byte = frame[47:40];
            5'd13:   cur_byte = frame[39:32];
            5'd14:   cur_byte = frame[31:24];
            5'd15:   cur_byte = frame[23:16];
            5'd16:   cur_byte = frame[15:8];
            5'd17:   cur_byte = frame[7:0];
            default: cur_byte = acc;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ord_ready  = 1'b0;
        tx_valid   = 1'b0;
        tx_last    = 1'b0;
        tx_data    = 8'h00;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                ord_ready = 1'b1;
                if (ord_valid && ord_qty != 32'd0) state_next = SEND;
            end
            SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = cur_byte;
                tx_last  = (idx == ORD_LAST_IDX);
                if (tx_ready && idx == ORD_LAST_IDX)
                    state_next = (IFG_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                busy = 1'b1;
                if (gap_cnt <= 16'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            frame        <= '0;
            idx          <= '0;
            acc          <= '0;
            seq          <= SEQ_INIT;
            gap_cnt      <= '0;
            msg_count    <= '0;
            reject_count <= '0;
        end else begin
            if (accept) begin
                if (ord_qty == 32'd0) begin
                    reject_count <= reject_count + 32'd1;
                end else begin
                    frame <= {ORD_MSG_TYPE, seq, ord_id,
                              (ord_side ? ORD_SIDE_SELL : ORD_SIDE_BUY),
                              ord_price, ord_qty};
                    idx   <= '0;
                end
            end
            if (tx_fire) begin
                idx <= idx + 5'd1;
                if (tx_last) begin
                    acc       <= '0;
                    msg_count <= msg_count + 32'd1;
                    seq       <= seq + 32'd1;
                    gap_cnt   <= GAP_LOAD;
                end else begin
                    acc <= acc ^ tx_data;
                end
            end
            if (state == GAP) gap_cnt <= gap_cnt - 16'd1;
        end
    end

endmodule

// File: tb/tb_order_entry_tx.sv
// tb/tb_order_entry_tx.sv - scoreboard bench for order_entry_tx with default and wrapping sequence setups
module tb_order_entry_tx;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        sel = 1'b0;
    logic        ord_valid = 1'b0;
    logic        ord_side = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] ord_id = '0, ord_price = '0, ord_qty = '0;

    logic        a_ord_ready, a_tx_valid, a_tx_last, a_busy;
    logic        b_ord_ready, b_tx_valid, b_tx_last, b_busy;
    logic [7:0]  a_tx_data, b_tx_data;
    logic [31:0] a_msg, a_rej, b_msg, b_rej;

    logic        m_ord_ready, m_tx_valid, m_tx_last, m_busy;
    logic [7:0]  m_tx_data;
    logic [31:0] m_msg, m_rej;

    int errors = 0;
    int checks = 0;
    logic [8:0]  sb_q[$];
    logic [31:0] exp_msg[2];
    logic [31:0] exp_rej[2];

    always #5 clk = ~clk;

    order_entry_tx #(.SEQ_INIT(32'd1), .IFG_CYCLES(4)) dut_a (
        .clk_sys(clk), .rstn(rstn), .ord_valid(ord_valid & ~sel), .ord_ready(a_ord_ready),
        .ord_id(ord_id), .ord_side(ord_side), .ord_price(ord_price), .ord_qty(ord_qty),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(tx_ready), .tx_last(a_tx_last),
        .busy(a_busy), .msg_count(a_msg), .reject_count(a_rej)
    );

    order_entry_tx #(.SEQ_INIT(32'hFFFFFFFF), .IFG_CYCLES(0)) dut_b (
        .clk_sys(clk), .rstn(rstn), .ord_valid(ord_valid & sel), .ord_ready(b_ord_ready),
        .ord_id(ord_id), .ord_side(ord_side), .ord_price(ord_price), .ord_qty(ord_qty),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(tx_ready), .tx_last(b_tx_last),
        .busy(b_busy), .msg_count(b_msg), .reject_count(b_rej)
    );

    assign m_ord_ready = sel ? b_ord_ready : a_ord_ready;
    assign m_tx_valid  = sel ? b_tx_valid  : a_tx_valid;
    assign m_tx_last   = sel ? b_tx_last   : a_tx_last;
    assign m_tx_data   = sel ? b_tx_data   : a_tx_data;
    assign m_busy      = sel ? b_busy      : a_busy;
    assign m_msg       = sel ? b_msg       : a_msg;
    assign m_rej       = sel ? b_rej       : a_rej;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] seqv, input logic [31:0] id, input logic side,
                              input logic [31:0] price, input logic [31:0] qty);
        logic [7:0] b[19];
        logic [7:0] x;
        x = 8'h00;
        b[0] = 8'h4F;
        for (int i = 0; i < 4; i++) begin
            b[1 + i]  = seqv[31 - 8*i -: 8];
            b[5 + i]  = id[31 - 8*i -: 8];
            b[10 + i] = price[31 - 8*i -: 8];
            b[14 + i] = qty[31 - 8*i -: 8];
        end
        b[9] = side ? 8'h53 : 8'h42;
        for (int i = 0; i < 18; i++) x = x ^ b[i];
        b[18] = x;
        for (int i = 0; i < 19; i++) sb_q.push_back({(i == 18), b[i]});
    endtask

    // Byte scoreboard plus stall-hold check, sampled mid-cycle.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_byte = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {22'd0, m_tx_valid, m_tx_last, m_tx_data}, {22'd0, 1'b1, prev_byte});
            if (m_tx_valid) begin
                check("ord_ready_in_send", {31'd0, m_ord_ready}, 32'd0);
                if (tx_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_byte unexpected actual=%h required=none", {m_tx_last, m_tx_data});
                    end else begin
                        check("tx_byte", {23'd0, m_tx_last, m_tx_data}, {23'd0, sb_q.pop_front()});
                    end
                end
            end
            prev_stall = m_tx_valid && !tx_ready;
            prev_byte  = {m_tx_last, m_tx_data};
        end
    end

    task automatic start_order(input logic s, input logic [31:0] id, input logic side,
                               input logic [31:0] price, input logic [31:0] qty,
                               input logic [31:0] seqv);
        int k;
        k = 0;
        sel = s;
        #1;
        while (!m_ord_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("ord_ready_wait", {31'd0, m_ord_ready}, 32'd1);
        ord_valid = 1'b1;
        ord_id    = id;
        ord_side  = side;
        ord_price = price;
        ord_qty   = qty;
        if (qty != 32'd0) push_frame(seqv, id, side, price, qty);
        else exp_rej[s] = exp_rej[s] + 32'd1;
        @(posedge clk); #1;
        ord_valid = 1'b0;
        ord_id    = $urandom;
        ord_price = $urandom;
        ord_qty   = $urandom;
        ord_side  = ~side;
        if (qty != 32'd0) begin
            check("valid_latency", {31'd0, m_tx_valid}, 32'd1);
            check("ord_ready_drop", {31'd0, m_ord_ready}, 32'd0);
        end else begin
            check("reject_no_valid", {31'd0, m_tx_valid}, 32'd0);
            check("reject_ready", {31'd0, m_ord_ready}, 32'd1);
            check("reject_count", m_rej, exp_rej[s]);
        end
    endtask

    task automatic finish_frame(input logic stall, input int exp_gap);
        bit done;
        int k;
        done = 1'b0;
        k = 0;
        while (!done && k < 400) begin
            tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            done = m_tx_valid && tx_ready && m_tx_last;
            @(posedge clk); #1;
            k++;
        end
        check("frame_done", {31'd0, done}, 32'd1);
        exp_msg[sel] = exp_msg[sel] + 32'd1;
        check("valid_after_last", {31'd0, m_tx_valid}, 32'd0);
        check("msg_count", m_msg, exp_msg[sel]);
        k = 0;
        while (!m_ord_ready && k < 50) begin
            check("gap_no_valid", {31'd0, m_tx_valid}, 32'd0);
            check("gap_busy", {31'd0, m_busy}, 32'd1);
            @(posedge clk); #1;
            k++;
        end
        check("gap_cycles", k, exp_gap);
        check("idle_not_busy", {31'd0, m_busy}, 32'd0);
        check("queue_drained", sb_q.size(), 32'd0);
    endtask

    typedef struct {
        logic        s;
        logic [31:0] id;
        logic        side;
        logic [31:0] price;
        logic [31:0] qty;
        logic        stall;
        logic [31:0] exp_seq;
        int          exp_gap;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b0, 32'h7,        1'b0, 32'h64,       32'hA,        1'b0, 32'd1,        4};
        tbl[1] = '{1'b0, 32'h7,        1'b0, 32'h64,       32'hA,        1'b1, 32'd2,        4};
        tbl[2] = '{1'b0, 32'h99,       1'b1, 32'h5,        32'h0,        1'b0, 32'd0,        0};
        tbl[3] = '{1'b0, 32'hDEADBEEF, 1'b1, 32'hFFFFFFFF, 32'h1,        1'b1, 32'd3,        4};
        tbl[4] = '{1'b1, 32'h1,        1'b1, 32'h5,        32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 0};
        tbl[5] = '{1'b1, 32'h2,        1'b0, 32'h80000000, 32'h7,        1'b1, 32'h0,        0};
        tbl[6] = '{1'b1, 32'h3,        1'b1, 32'h1234,     32'h0,        1'b0, 32'h0,        0};
        tbl[7] = '{1'b1, 32'h4,        1'b0, 32'h1,        32'h2,        1'b0, 32'h1,        0};
        exp_msg = '{32'd0, 32'd0};
        exp_rej = '{32'd0, 32'd0};

        #1 rstn = 1'b0;
        #2;
        check("rst_a_valid", {31'd0, a_tx_valid}, 32'd0);
        check("rst_a_last", {31'd0, a_tx_last}, 32'd0);
        check("rst_a_busy", {31'd0, a_busy}, 32'd0);
        check("rst_a_data", {24'd0, a_tx_data}, 32'd0);
        check("rst_a_ready", {31'd0, a_ord_ready}, 32'd1);
        check("rst_a_msg", a_msg, 32'd0);
        check("rst_a_rej", a_rej, 32'd0);
        check("rst_b_ready", {31'd0, b_ord_ready}, 32'd1);
        check("rst_b_msg", b_msg, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            start_order(tbl[i].s, tbl[i].id, tbl[i].side, tbl[i].price, tbl[i].qty, tbl[i].exp_seq);
            if (tbl[i].qty != 32'd0) begin
                finish_frame(tbl[i].stall, tbl[i].exp_gap);
            end else begin
                @(posedge clk); #1;
                check("reject_stays_idle", {31'd0, m_tx_valid}, 32'd0);
            end
        end

        // Reset in the middle of a frame: nothing more may come out of the abandoned frame.
        start_order(1'b0, 32'h11, 1'b0, 32'h22, 32'h33, 32'd4);
        tx_ready = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("bytes_before_reset", sb_q.size(), 32'd12);
        rstn = 1'b0;
        #1;
        check("midrst_valid", {31'd0, a_tx_valid}, 32'd0);
        check("midrst_last", {31'd0, a_tx_last}, 32'd0);
        check("midrst_busy", {31'd0, a_busy}, 32'd0);
        check("midrst_ready", {31'd0, a_ord_ready}, 32'd1);
        check("midrst_msg", a_msg, 32'd0);
        check("midrst_rej", a_rej, 32'd0);
        check("midrst_b_msg", b_msg, 32'd0);
        sb_q.delete();
        exp_msg = '{32'd0, 32'd0};
        exp_rej = '{32'd0, 32'd0};
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        start_order(1'b0, 32'h55, 1'b1, 32'h66, 32'h77, 32'd1);
        finish_frame(1'b1, 4);
        start_order(1'b1, 32'h88, 1'b0, 32'h99, 32'hAA, 32'hFFFFFFFF);
        finish_frame(1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
